data_mem_bridge: RTL and testbench

Sits directly downstream of the core's data-memory port: consumes ALUResult (address), WriteData, MemWrite/MemRead and the access size, and returns ReadData. It converts the core's single-cycle memory access into a valid/ready bus transaction with byte-lane strobes and load extension, stalling the core until the access completes. It also flags misaligned and timed-out accesses. The core stalls by holding PC and register writes while stall=1.

---
 rtl/data_mem_bridge_pkg.sv | 25 ++
 rtl/data_mem_bridge_lane_align.sv | 58 +++++
 rtl/data_mem_bridge.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_bridge.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_bridge_pkg.sv
// Shared types for the core data-memory bridge.
// Access sizes and bridge FSM states.
package data_mem_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam int LANES = 4;

  // Counter width able to hold 0..n-1 with headroom.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/data_mem_bridge_lane_align.sv
// Byte-lane steering for the data-memory bridge.
// Store strobes/replication, misalignment, load extension.
module data_lane_align
  import data_mem_bridge_pkg::*;
(
  input  logic [1:0]  i_req_size,
  input  logic [1:0]  i_req_off,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_rdata,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shift;
  logic        w_sb;
  logic        w_sh;

  // Request side: strobes, replicated lane data, alignment check.
  // Size code 3 is treated as a word access.
  always_comb begin
    o_strb       = 4'b1111;
    o_wdata      = i_req_wdata;
    o_misaligned = |i_req_off;
    case (size_e'(i_req_size))
      SZ_B: begin
        o_strb       = 4'b0001 << i_req_off;
        o_wdata      = {4{i_req_wdata[7:0]}};
        o_misaligned = 1'b0;
      end
      SZ_H: begin
        o_strb       = 4'b0011 << i_req_off;
        o_wdata      = {2{i_req_wdata[15:0]}};
        o_misaligned = i_req_off[0];
      end
      default: ;
    endcase
  end

  assign w_shift = i_ld_rdata >> {i_ld_off, 3'b000};
  assign w_sb    = ~i_ld_unsigned & w_shift[7];
  assign w_sh    = ~i_ld_unsigned & w_shift[15];

  // Response side: right-align and sign/zero extend.
  always_comb begin
    o_ld_data = w_shift;
    case (size_e'(i_ld_size))
      SZ_B: o_ld_data = {{24{w_sb}}, w_shift[7:0]};
      SZ_H: o_ld_data = {{16{w_sh}}, w_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// Core data-port to valid/ready bus bridge.
// Stalls the core until the bus access completes.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [1:0]        core_size,
  input  logic              core_unsigned,
  output logic [DATA_W-1:0] core_rdata,
  output logic              stall,
  output logic              fault,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [3:0]        bus_wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e r_state;
  lsu_state_e w_next;

  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [3:0]        r_strb;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic              r_uns;
  logic [DATA_W-1:0] r_rdata;
  logic              r_fault;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_run;
  logic              w_mis_raw;
  logic              w_mis;
  logic              w_start;
  logic              w_tmo;
  logic              w_busy;
  logic [3:0]        w_strb;
  logic [3:0]        w_req_strb;
  logic [31:0]       w_lane;
  logic [31:0]       w_ld;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_rdata_nx;
  logic              w_fault_nx;

  data_lane_align u_align (
    .i_req_size    (core_size),
    .i_req_off     (core_addr[1:0]),
    .i_req_wdata   (core_wdata),
    .i_ld_size     (r_size),
    .i_ld_off      (r_off),
    .i_ld_unsigned (r_uns),
    .i_ld_rdata    (bus_rdata),
    .o_strb        (w_strb),
    .o_wdata       (w_lane),
    .o_misaligned  (w_mis_raw),
    .o_ld_data     (w_ld)
  );

  // Reset also masks the combinational request path.
  assign w_run      = ~reset;
  assign w_mis      = w_run & core_req & w_mis_raw;
  assign w_start    = w_run & core_req & ~w_mis_raw
                    & (r_state == IDLE);
  assign w_tmo      = (r_cnt == CNT_MAX);
  assign w_busy     = (r_state == REQ) | (r_state == RESP);
  assign w_waddr    = {core_addr[ADDR_W-1:2], 2'b00};
  assign w_req_strb = core_we ? w_strb : 4'b0000;

  // Next state plus captured load data and fault flag.
  always_comb begin
    w_next     = r_state;
    w_rdata_nx = r_rdata;
    w_fault_nx = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_next = bus_ready ? RESP : REQ;
      end
      REQ: begin
        if (w_tmo) begin
          w_next     = DONE;
          w_fault_nx = 1'b1;
          w_rdata_nx = '0;
        end else if (bus_ready) begin
          w_next = RESP;
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          w_next = DONE;
          if (bus_err) begin
            w_fault_nx = 1'b1;
            w_rdata_nx = '0;
          end else if (!r_we) begin
            w_rdata_nx = w_ld;
          end
        end else if (w_tmo) begin
          w_next     = DONE;
          w_fault_nx = 1'b1;
          w_rdata_nx = '0;
        end
      end
      DONE: w_next = IDLE;
    endcase
  end

  // First request cycle drives the bus straight from the core
  // so a ready bus accepts it without an extra cycle.
  assign bus_valid  = w_start | (r_state == REQ);
  assign bus_addr   = w_start ? w_waddr    : r_addr;
  assign bus_we     = w_start ? core_we    : r_we;
  assign bus_wstrb  = w_start ? w_req_strb : r_strb;
  assign bus_wdata  = w_start ? w_lane     : r_wdata;

  assign stall      = w_run & core_req & ~w_mis_raw
                    & (r_state != DONE);
  assign fault      = ((r_state == IDLE) & w_mis)
                    | ((r_state == DONE) & r_fault);
  assign core_rdata = ((r_state == IDLE) & w_mis) ? '0 : r_rdata;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Capture the request so the bus sees it stable in REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_strb  <= 4'b0000;
      r_wdata <= '0;
      r_size  <= 2'b00;
      r_off   <= 2'b00;
      r_uns   <= 1'b0;
    end else if (w_start) begin
      r_addr  <= w_waddr;
      r_we    <= core_we;
      r_strb  <= w_req_strb;
      r_wdata <= w_lane;
      r_size  <= core_size;
      r_off   <= core_addr[1:0];
      r_uns   <= core_unsigned;
    end
  end

  // Timeout counter over REQ and RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_cnt <= '0;
    else if (w_start) r_cnt <= '0;
    else if (w_busy)  r_cnt <= r_cnt + 1'b1;
  end

  // Load result and completion fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      r_rdata <= w_rdata_nx;
      r_fault <= w_fault_nx;
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge.
// Scoreboard of expected bus/core results per access.
module tb_data_mem_bridge;

  localparam int TO = 64;

  typedef struct packed {
    logic        done;
    logic        saw_valid;
    logic        hs;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        fault;
    logic [7:0]  stalls;
  } rec_t;

  logic        clk;
  logic        reset;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [1:0]  core_size;
  logic        core_unsigned;
  logic [31:0] core_rdata;
  logic        stall;
  logic        fault;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int   n_vec;
  int   n_err;
  rec_t exp_q[$];

  data_mem_bridge #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_req      (core_req),
    .core_we       (core_we),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_size     (core_size),
    .core_unsigned (core_unsigned),
    .core_rdata    (core_rdata),
    .stall         (stall),
    .fault         (fault),
    .bus_valid     (bus_valid),
    .bus_ready     (bus_ready),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_wstrb     (bus_wstrb),
    .bus_wdata     (bus_wdata),
    .bus_rvalid    (bus_rvalid),
    .bus_rdata     (bus_rdata),
    .bus_err       (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(
    input logic [31:0] a, input logic [3:0] s,
    input logic [31:0] wd, input logic we,
    input logic [31:0] rd, input logic f,
    input int st);
    rec_t e;
    e        = '0;
    e.addr   = a;
    e.strb   = s;
    e.wdata  = wd;
    e.we     = we;
    e.rdata  = rd;
    e.fault  = f;
    e.stalls = 8'(st);
    return e;
  endfunction

  // Drive one core access; bus accepts after rwait cycles and
  // answers the cycle after acceptance. Returns what was seen.
  task automatic run_access(
    input logic we, input logic [31:0] a,
    input logic [31:0] wd, input logic [1:0] sz,
    input logic u, input logic [31:0] rd,
    input logic er, input int rwait,
    output rec_t o);
    rec_t r;
    int   hs_at;
    r     = '0;
    hs_at = -1;
    @(negedge clk);
    core_req      = 1'b1;
    core_we       = we;
    core_addr     = a;
    core_wdata    = wd;
    core_size     = sz;
    core_unsigned = u;
    for (int c = 0; c < 200; c++) begin
      bus_ready  = (hs_at < 0) && (c >= rwait);
      bus_rvalid = (hs_at >= 0) && (c == hs_at + 1);
      bus_err    = bus_rvalid & er;
      bus_rdata  = bus_rvalid ? rd : 32'h0;
      #1;
      if (bus_valid) r.saw_valid = 1'b1;
      if (bus_valid && bus_ready) begin
        hs_at   = c;
        r.hs    = 1'b1;
        r.addr  = bus_addr;
        r.strb  = bus_wstrb;
        r.wdata = bus_wdata;
        r.we    = bus_we;
      end
      if (!stall) begin
        r.done  = 1'b1;
        r.rdata = core_rdata;
        r.fault = fault;
        break;
      end
      r.stalls = r.stalls + 8'd1;
      @(negedge clk);
    end
    core_req   = 1'b0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_err    = 1'b0;
    bus_rdata  = 32'h0;
    o = r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({stall, fault, bus_valid, bus_we, bus_wstrb} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctl got %b exp 00000000",
        {stall, fault, bus_valid, bus_we, bus_wstrb});
    end
    n_vec++;
    if ({bus_addr, bus_wdata, core_rdata} !== 96'h0) begin
      n_err++;
      $display("FAIL reset_data got %h/%h/%h exp 0",
        bus_addr, bus_wdata, core_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if ({stall, bus_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL post_reset got %b exp 00", {stall, bus_valid});
    end
  endtask

  task automatic test_word_store();
    rec_t o, e;
    exp_q.push_back(mk(32'h100, 4'b1111, 32'hDEADBEEF,
                       1'b1, 32'h0, 1'b0, 2));
    run_access(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0,
               32'h0, 1'b0, 0, o);
    e = exp_q.pop_front();
    n_vec++;
    if ({o.done, o.hs, o.addr, o.strb, o.wdata, o.we} !==
        {2'b11, e.addr, e.strb, e.wdata, e.we}) begin
      n_err++;
      $display("FAIL wstore_bus got %b%b %h %b %h %b exp 11 %h %b %h %b",
        o.done, o.hs, o.addr, o.strb, o.wdata, o.we,
        e.addr, e.strb, e.wdata, e.we);
    end
    n_vec++;
    if ({o.stalls, o.fault} !== {e.stalls, e.fault}) begin
      n_err++;
      $display("FAIL wstore_stall got %0d/%b exp %0d/%b",
        o.stalls, o.fault, e.stalls, e.fault);
    end
  endtask

  task automatic test_byte_load();
    rec_t o, e;
    exp_q.push_back(mk(32'h200, 4'b0000, 32'h0, 1'b0,
                       32'hFFFFFF80, 1'b0, 2));
    exp_q.push_back(mk(32'h200, 4'b0000, 32'h0, 1'b0,
                       32'h00000080, 1'b0, 2));
    for (int k = 0; k < 2; k++) begin
      run_access(1'b0, 32'h203, 32'h0, 2'd0, k[0],
                 32'h80FF1234, 1'b0, 0, o);
      e = exp_q.pop_front();
      n_vec++;
      if ({o.addr, o.strb, o.we} !== {e.addr, e.strb, e.we}) begin
        n_err++;
        $display("FAIL bload%0d_bus got %h %b %b exp %h %b %b",
          k, o.addr, o.strb, o.we, e.addr, e.strb, e.we);
      end
      n_vec++;
      if ({o.done, o.rdata, o.fault} !== {1'b1, e.rdata, e.fault}) begin
        n_err++;
        $display("FAIL bload%0d_data got %h f%b exp %h f%b",
          k, o.rdata, o.fault, e.rdata, e.fault);
      end
    end
  endtask

  task automatic test_half_load_byte_store();
    rec_t o, e;
    exp_q.push_back(mk(32'h300, 4'b0000, 32'h0, 1'b0,
                       32'h0000ABCD, 1'b0, 2));
    run_access(1'b0, 32'h302, 32'h0, 2'd1, 1'b1,
               32'hABCD0000, 1'b0, 0, o);
    e = exp_q.pop_front();
    n_vec++;
    if ({o.strb, o.rdata} !== {e.strb, e.rdata}) begin
      n_err++;
      $display("FAIL hload got %b %h exp %b %h",
        o.strb, o.rdata, e.strb, e.rdata);
    end
    exp_q.push_back(mk(32'h300, 4'b0010, 32'h5A5A5A5A, 1'b1,
                       32'h0000ABCD, 1'b0, 2));
    run_access(1'b1, 32'h301, 32'h0000005A, 2'd0, 1'b0,
               32'h0, 1'b0, 0, o);
    e = exp_q.pop_front();
    n_vec++;
    if ({o.addr, o.strb, o.wdata, o.rdata} !==
        {e.addr, e.strb, e.wdata, e.rdata}) begin
      n_err++;
      $display("FAIL bstore got %h %b %h %h exp %h %b %h %h",
        o.addr, o.strb, o.wdata, o.rdata,
        e.addr, e.strb, e.wdata, e.rdata);
    end
  endtask

  task automatic test_reset_mid();
    rec_t o, e;
    @(negedge clk);
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 32'h400;
    core_size = 2'd2;
    bus_ready = 1'b1;
    #1;
    n_vec++;
    if (bus_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_valid got %b exp 1", bus_valid);
    end
    @(negedge clk);
    bus_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({stall, fault, bus_valid, bus_we, bus_wstrb,
         bus_addr, bus_wdata, core_rdata} !== 104'h0) begin
      n_err++;
      $display("FAIL rmid_clear got %b%b%b%b %b %h %h %h exp 0",
        stall, fault, bus_valid, bus_we, bus_wstrb,
        bus_addr, bus_wdata, core_rdata);
    end
    @(negedge clk);
    reset      = 1'b0;
    core_req   = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h99999999;
    @(negedge clk);
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    #1;
    n_vec++;
    if ({stall, core_rdata} !== 33'h0) begin
      n_err++;
      $display("FAIL rmid_late got %b %h exp 0 0",
        stall, core_rdata);
    end
    exp_q.push_back(mk(32'h404, 4'b0000, 32'h0, 1'b0,
                       32'hCAFEF00D, 1'b0, 2));
    run_access(1'b0, 32'h404, 32'h0, 2'd2, 1'b0,
               32'hCAFEF00D, 1'b0, 0, o);
    e = exp_q.pop_front();
    n_vec++;
    if ({o.done, o.addr, o.rdata, o.stalls, o.fault} !==
        {1'b1, e.addr, e.rdata, e.stalls, e.fault}) begin
      n_err++;
      $display("FAIL rmid_next got %h %h %0d f%b exp %h %h %0d f%b",
        o.addr, o.rdata, o.stalls, o.fault,
        e.addr, e.rdata, e.stalls, e.fault);
    end
  endtask

  task automatic test_misaligned();
    rec_t o, e;
    logic [31:0] a_t [2];
    logic [1:0]  s_t [2];
    a_t[0] = 32'h102; s_t[0] = 2'd2;
    a_t[1] = 32'h303; s_t[1] = 2'd1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(32'h0, 4'b0, 32'h0, 1'b0,
                         32'h0, 1'b1, 0));
      run_access(k[0], a_t[k], 32'h11111111, s_t[k], 1'b0,
                 32'h0, 1'b0, 0, o);
      e = exp_q.pop_front();
      n_vec++;
      if ({o.done, o.saw_valid, o.stalls, o.fault, o.rdata} !==
          {2'b10, e.stalls, e.fault, e.rdata}) begin
        n_err++;
        $display("FAIL misal%0d got d%b v%b %0d f%b %h exp d1 v0 %0d f%b %h",
          k, o.done, o.saw_valid, o.stalls, o.fault, o.rdata,
          e.stalls, e.fault, e.rdata);
      end
      #1;
      n_vec++;
      if ({fault, core_rdata} !== {1'b0, 32'hCAFEF00D}) begin
        n_err++;
        $display("FAIL misal%0d_after got f%b %h exp f0 cafef00d",
          k, fault, core_rdata);
      end
    end
  endtask

  task automatic test_bus_err();
    rec_t o, e;
    exp_q.push_back(mk(32'h500, 4'b0000, 32'h0, 1'b0,
                       32'h0, 1'b1, 2));
    run_access(1'b0, 32'h500, 32'h0, 2'd2, 1'b0,
               32'hFFFFFFFF, 1'b1, 0, o);
    e = exp_q.pop_front();
    n_vec++;
    if ({o.done, o.rdata, o.fault, o.stalls} !==
        {1'b1, e.rdata, e.fault, e.stalls}) begin
      n_err++;
      $display("FAIL buserr got %h f%b %0d exp %h f%b %0d",
        o.rdata, o.fault, o.stalls, e.rdata, e.fault, e.stalls);
    end
  endtask

  task automatic test_back_to_back();
    rec_t o, e;
    logic        we_t [5];
    logic [31:0] a_t  [5];
    logic [31:0] wd_t [5];
    logic [1:0]  sz_t [5];
    logic        u_t  [5];
    logic [31:0] rd_t [5];
    int          rw_t [5];
    we_t[0]=0; a_t[0]=32'h602; wd_t[0]=0; sz_t[0]=1; u_t[0]=0;
    rd_t[0]=32'h80015555; rw_t[0]=2;
    we_t[1]=1; a_t[1]=32'h702; wd_t[1]=32'hFFFF1234; sz_t[1]=1;
    u_t[1]=0; rd_t[1]=0; rw_t[1]=0;
    we_t[2]=0; a_t[2]=32'h701; wd_t[2]=0; sz_t[2]=0; u_t[2]=1;
    rd_t[2]=32'h0000AB00; rw_t[2]=1;
    we_t[3]=1; a_t[3]=32'h7FC; wd_t[3]=32'h11223344; sz_t[3]=2;
    u_t[3]=0; rd_t[3]=0; rw_t[3]=3;
    we_t[4]=0; a_t[4]=32'h700; wd_t[4]=0; sz_t[4]=0; u_t[4]=0;
    rd_t[4]=32'h0000007F; rw_t[4]=0;
    exp_q.push_back(mk(32'h600, 4'b0000, 32'h0, 1'b0,
                       32'hFFFF8001, 1'b0, 4));
    exp_q.push_back(mk(32'h700, 4'b1100, 32'h12341234, 1'b1,
                       32'hFFFF8001, 1'b0, 2));
    exp_q.push_back(mk(32'h700, 4'b0000, 32'h0, 1'b0,
                       32'h000000AB, 1'b0, 3));
    exp_q.push_back(mk(32'h7FC, 4'b1111, 32'h11223344, 1'b1,
                       32'h000000AB, 1'b0, 5));
    exp_q.push_back(mk(32'h700, 4'b0000, 32'h0, 1'b0,
                       32'h0000007F, 1'b0, 2));
    for (int k = 0; k < 5; k++) begin
      run_access(we_t[k], a_t[k], wd_t[k], sz_t[k], u_t[k],
                 rd_t[k], 1'b0, rw_t[k], o);
      e = exp_q.pop_front();
      n_vec++;
      if ({o.done, o.addr, o.strb, o.we} !==
          {1'b1, e.addr, e.strb, e.we}) begin
        n_err++;
        $display("FAIL b2b%0d_bus got d%b %h %b %b exp %h %b %b",
          k, o.done, o.addr, o.strb, o.we, e.addr, e.strb, e.we);
      end
      if (e.we) begin
        n_vec++;
        if (o.wdata !== e.wdata) begin
          n_err++;
          $display("FAIL b2b%0d_wdata got %h exp %h",
            k, o.wdata, e.wdata);
        end
      end
      n_vec++;
      if ({o.rdata, o.fault, o.stalls} !==
          {e.rdata, e.fault, e.stalls}) begin
        n_err++;
        $display("FAIL b2b%0d_resp got %h f%b %0d exp %h f%b %0d",
          k, o.rdata, o.fault, o.stalls,
          e.rdata, e.fault, e.stalls);
      end
    end
  endtask

  task automatic test_timeout();
    rec_t o, e;
    exp_q.push_back(mk(32'h0, 4'b0, 32'h0, 1'b0,
                       32'h0, 1'b1, TO + 1));
    run_access(1'b0, 32'h800, 32'h0, 2'd2, 1'b0,
               32'h0, 1'b0, 1000, o);
    e = exp_q.pop_front();
    n_vec++;
    if ({o.done, o.hs, o.fault, o.rdata, o.stalls} !==
        {2'b10, e.fault, e.rdata, e.stalls}) begin
      n_err++;
      $display("FAIL timeout got d%b h%b f%b %h %0d exp d1 h0 f%b %h %0d",
        o.done, o.hs, o.fault, o.rdata, o.stalls,
        e.fault, e.rdata, e.stalls);
    end
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h12345678;
    #1;
    n_vec++;
    if ({fault, bus_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL tmo_pulse got %b exp 00", {fault, bus_valid});
    end
    @(negedge clk);
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    #1;
    n_vec++;
    if (core_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL tmo_late got %h exp 0", core_rdata);
    end
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    reset         = 1'b1;
    core_req      = 1'b0;
    core_we       = 1'b0;
    core_addr     = 32'h0;
    core_wdata    = 32'h0;
    core_size     = 2'd0;
    core_unsigned = 1'b0;
    bus_ready     = 1'b0;
    bus_rvalid    = 1'b0;
    bus_rdata     = 32'h0;
    bus_err       = 1'b0;
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_load_byte_store();
    test_reset_mid();
    test_misaligned();
    test_bus_err();
    test_back_to_back();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_err);
    $finish;
  end

endmodule
